// File: rtl/fifo_pkg.sv
// Shared helpers and defaults for the async FIFO read and write sides.
package fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH      = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned PTR_MAX_W          = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down; zero upper bits leave narrower pointers unaffected.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int s = 1; s < int'(PTR_MAX_W); s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing a multi-bit Gray pointer into rd_clk.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             rd_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: pointer sync, memory read issue and a
// 2-entry first-word-fall-through output buffer.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] rd_ptr_gray,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] rd_count
);

  logic [ADDR_WIDTH-1:0] wr_gray_sync;
  logic [ADDR_WIDTH-1:0] wr_ptr_sync;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
  logic                  inflight;
  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic [1:0]            occ_after_pop;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [DATA_WIDTH-1:0] buf0_nxt;
  logic [DATA_WIDTH-1:0] buf1_nxt;
  logic                  pop;

  sync_2ff #(
    .WIDTH (ADDR_WIDTH)
  ) u_wr_sync (
    .rd_clk (rd_clk),
    .rst_n  (rst_n),
    .d      (wr_ptr_gray),
    .q      (wr_gray_sync)
  );

  assign wr_ptr_sync = ADDR_WIDTH'(gray2bin(ptr_t'(wr_gray_sync)));

  // Full compare including the wrap bit keeps empty and full distinct.
  assign empty    = (rd_ptr == wr_ptr_sync);
  assign rd_count = wr_ptr_sync - rd_ptr;

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;
  assign pop       = out_valid && out_ready;

  // Issue only when the word (plus any already in flight) is guaranteed a slot.
  assign mem_rd_en  = !empty && (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(mem_rd_en);

  // Buffer update: buf0 is always the oldest entry; pop shifts, write fills next free slot.
  always_comb begin
    occ_nxt       = occ;
    occ_after_pop = occ;
    buf0_nxt      = buf0;
    buf1_nxt      = buf1;
    if (pop) begin
      buf0_nxt      = buf1;
      occ_after_pop = occ - 2'd1;
    end
    occ_nxt = occ_after_pop;
    if (inflight) begin
      occ_nxt = occ_after_pop + 2'd1;
      if (occ_after_pop == 2'd0) begin
        buf0_nxt = mem_rd_data;
      end else begin
        buf1_nxt = mem_rd_data;
      end
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      rd_ptr_gray <= '0;
      inflight    <= 1'b0;
      occ         <= 2'd0;
      buf0        <= '0;
      buf1        <= '0;
    end else begin
      rd_ptr      <= rd_ptr_nxt;
      rd_ptr_gray <= ADDR_WIDTH'(bin2gray(ptr_t'(rd_ptr_nxt)));
      inflight    <= mem_rd_en;
      occ         <= occ_nxt;
      buf0        <= buf0_nxt;
      buf1        <= buf1_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed latency/backpressure/wrap/reset
// scenarios plus randomized traffic against a word-level scoreboard.
module tb_fifo_rd_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 5;

  logic          rd_clk = 1'b0;
  logic          rst_n  = 1'b1;
  logic [AW-1:0] wr_ptr_gray;
  logic [AW-1:0] rd_ptr_gray;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          empty;
  logic [AW-1:0] rd_count;

  fifo_rd_ctrl #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .rd_clk      (rd_clk),
    .rst_n       (rst_n),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .empty       (empty),
    .rd_count    (rd_count)
  );

  always #5 rd_clk = ~rd_clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            wr_cnt    = 0;
  int            rd_issued = 0;
  int            pops      = 0;
  int            h1        = 0;
  int            h2        = 0;
  bit            last_en   = 1'b0;
  logic [AW-1:0] prev_gray = '0;
  int            mem_addr  = 0;

  logic [AW-1:0] m_exp_cnt;
  int            m_held;
  bit            m_pop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] gray(input int v);
    logic [AW-1:0] b;
    b = AW'(v);
    return b ^ (b >> 1);
  endfunction

  // Memory with one-cycle registered read, sequential addresses.
  always @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_data <= '0;
      mem_addr    <= 0;
    end else if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr % DEPTH];
      mem_addr    <= mem_addr + 1;
    end
  end

  // Word-level model: published write count seen two edges late, words held = issued - popped.
  always @(negedge rd_clk) begin
    if (!rst_n) begin
      rd_issued = 0;
      pops      = 0;
      h1        = 0;
      h2        = 0;
      last_en   = 1'b0;
      prev_gray = '0;
    end else begin
      m_exp_cnt = AW'(h2 - rd_issued);
      chk("rd_count", 32'(rd_count), 32'(m_exp_cnt));
      chk("empty", 32'(empty), 32'(m_exp_cnt == '0));
      chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(gray(rd_issued)));
      chk("gray_step", 32'($countones(rd_ptr_gray ^ prev_gray) <= 1), 32'd1);
      m_held = rd_issued - pops;
      chk("out_valid", 32'(out_valid), 32'((m_held - int'(last_en)) != 0));
      m_pop = out_valid && out_ready;
      chk("mem_rd_en", 32'(mem_rd_en), 32'((m_exp_cnt != '0) && (m_held < 2 + int'(m_pop))));
      if (m_pop) begin
        if (exp_q.size() == 0) chk("spurious_pop", 32'(out_valid), 32'd0);
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        pops++;
      end
      rd_issued = rd_issued + int'(mem_rd_en);
      last_en   = mem_rd_en;
      prev_gray = rd_ptr_gray;
      h2        = h1;
      h1        = wr_cnt;
    end
  end

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d, input bit publish);
    mem[wr_cnt % DEPTH] = d;
    exp_q.push_back(d);
    wr_cnt++;
    if (publish) wr_ptr_gray = gray(wr_cnt);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    wr_cnt      = 0;
    wr_ptr_gray = '0;
    out_ready   = 1'b0;
    exp_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || !empty) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int written;
    int cyc;
    int burst_left;

    out_ready   = 1'b0;
    wr_ptr_gray = '0;
    #2;
    do_reset();

    // Reset values
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_rd_ptr_gray", 32'(rd_ptr_gray), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);

    // Single word latency
    out_ready = 1'b1;
    write_word(8'hA5, 1'b1);
    step();
    chk("lat_e0_empty", 32'(empty), 32'd1);
    step();
    chk("lat_e1_empty", 32'(empty), 32'd0);
    chk("lat_e1_rd_en", 32'(mem_rd_en), 32'd1);
    step();
    chk("lat_e2_valid", 32'(out_valid), 32'd0);
    step();
    chk("lat_e3_valid", 32'(out_valid), 32'd1);
    chk("lat_e3_data", 32'(out_data), 32'hA5);
    step();
    chk("lat_pop_valid", 32'(out_valid), 32'd0);
    chk("lat_pop_empty", 32'(empty), 32'd1);

    // Backpressure with 16 words
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      write_word(DW'(i), 1'b1);
      step();
    end
    repeat (6) step();
    chk("bp_rd_count", 32'(rd_count), 32'd14);
    chk("bp_rd_en", 32'(mem_rd_en), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", 32'(out_data), 32'h00);
    repeat (3) step();
    chk("bp_data_hold", 32'(out_data), 32'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("bp_throughput", 32'(out_valid), 32'd1);
      step();
    end
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_done_empty", 32'(empty), 32'd1);

    // Full and pointer wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_word(DW'(8'h40 + i), 1'b0);
    wr_ptr_gray = gray(wr_cnt);
    step();
    step();
    chk("wrap_full_cnt1", 32'(rd_count), 32'd16);
    chk("wrap_full_empty1", 32'(empty), 32'd0);
    wait_drain("wrap_drain1", 100);
    for (int i = 0; i < 16; i++) write_word(DW'(8'h80 + i), 1'b0);
    wr_ptr_gray = gray(wr_cnt);
    step();
    step();
    chk("wrap_full_cnt2", 32'(rd_count), 32'd16);
    chk("wrap_full_empty2", 32'(empty), 32'd0);
    wait_drain("wrap_drain2", 100);
    chk("wrap_gray_end", 32'(rd_ptr_gray), 32'd0);

    // Random stalls and write bursts
    written    = 0;
    cyc        = 0;
    burst_left = 0;
    while ((written < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (burst_left == 0 && $urandom_range(0, 5) == 0) burst_left = $urandom_range(1, 24);
      if (burst_left > 0 && written < 1000 && (wr_cnt - rd_issued) < int'(DEPTH)) begin
        write_word(DW'($urandom), 1'b1);
        written++;
        burst_left--;
      end
      step();
      cyc++;
    end
    chk("rand_timeout", 32'(cyc < 20000), 32'd1);
    chk("rand_written", 32'(written), 32'd1000);
    wait_drain("rand_drain", 50);

    // Mid-stream reset with a word buffered and one in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(DW'(8'hC0 + i), 1'b0);
    wr_ptr_gray = gray(wr_cnt);
    repeat (4) step();
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    rst_n       = 1'b0;
    wr_cnt      = 0;
    wr_ptr_gray = '0;
    exp_q.delete();
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data", 32'(out_data), 32'd0);
    chk("mr_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_rd_count", 32'(rd_count), 32'd0);
    chk("mr_rd_ptr_gray", 32'(rd_ptr_gray), 32'd0);
    step();
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      chk("mr_stale", 32'(out_valid), 32'd0);
      step();
    end
    write_word(8'h3C, 1'b1);
    repeat (4) step();
    chk("mr_new_valid", 32'(out_valid), 32'd1);
    chk("mr_new_data", 32'(out_data), 32'h3C);
    wait_drain("mr_drain", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DEPTH, 16, memory word count, power of two.
- DATA_WIDTH, 8, data word width.
- ADDR_WIDTH, $clog2(DEPTH)+1, pointer width including the wrap bit.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- rd_clk, in, 1, the single clock.
- rst_n, in, 1, reset: asynchronous, active-low.
- wr_ptr_gray, in, ADDR_WIDTH, Gray-coded write pointer from the write domain; asynchronous to rd_clk.
- rd_ptr_gray, out, ADDR_WIDTH, registered Gray-coded read pointer, sent back to the write domain.
- mem_rd_en, out, 1, read strobe to the memory.
- mem_rd_data, in, DATA_WIDTH, memory read data, registered in memory one cycle after mem_rd_en.
- out_data, out, DATA_WIDTH, first-word-fall-through data to the consumer.
- out_valid, out, 1, out_data is valid.
- out_ready, in, 1, consumer accepts.
- empty, out, 1, no unread words remain in memory.
- rd_count, out, ADDR_WIDTH, words in memory not yet issued for read.

Function
REQ-003 wr_ptr_gray SHALL pass through a 2-flop synchronizer; the second stage is converted Gray-to-binary into wr_ptr_sync.
REQ-004 The internal binary rd_ptr SHALL increment by 1 on each cycle with mem_rd_en=1, wrapping modulo 2^ADDR_WIDTH.
REQ-005 rd_ptr_gray SHALL be registered as (rd_ptr ^ (rd_ptr>>1)), updated on the same edge as rd_ptr.
REQ-006 empty SHALL equal (rd_ptr == wr_ptr_sync), all ADDR_WIDTH bits compared, combinationally.
REQ-007 rd_count SHALL equal (wr_ptr_sync - rd_ptr) modulo 2^ADDR_WIDTH and SHALL range over 0..DEPTH.
REQ-008 inflight SHALL be a register holding the previous cycle's mem_rd_en; when inflight=1, mem_rd_data is valid this cycle.
REQ-009 A 2-entry output buffer SHALL hold words; occ (0..2) is the number of entries held; pop = out_valid && out_ready.
REQ-010 mem_rd_en SHALL equal !empty && (occ + inflight < 2 + pop); the buffer SHALL never overflow.
REQ-011 If inflight=1, mem_rd_data SHALL be written into the buffer on the clock edge that ends that cycle; a write and a pop in the same cycle SHALL both take effect.
REQ-012 out_valid SHALL equal (occ != 0); out_data SHALL be the oldest entry.
REQ-013 While out_valid && !out_ready, out_data SHALL hold stable.
REQ-014 Words SHALL be delivered in write order, with no loss or duplication across pointer wrap.
REQ-015 Latency SHALL be as follows, counting edge 0 as the first rd_clk edge sampling a new wr_ptr_gray:
- empty deasserts after edge 1.
- mem_rd_en is high in the cycle after edge 1.
- out_valid is high after edge 3.
REQ-016 With out_ready held at 1 and the memory non-empty, throughput SHALL be 1 word per cycle.
REQ-017 rd_count = DEPTH (full) SHALL be handled as normal; empty and full SHALL never be confused, since the wrap bit distinguishes them.

Reset
REQ-018 rst_n=0 SHALL asynchronously clear all of the following:
- the sync flops, rd_ptr, rd_ptr_gray, inflight, occ and buffer contents;
- out_data=0, out_valid=0, mem_rd_en=0, empty=1, rd_count=0.
REQ-019 Reset during operation SHALL discard in-flight and buffered words; the first cycle after release SHALL behave as after power-up.
REQ-020 Reset release SHALL be synchronized to rd_clk externally; the block SHALL not require any extra deassertion logic.

Structure
REQ-021 Package fifo_pkg SHALL hold the bin2gray and gray2bin functions and the default DEPTH and DATA_WIDTH constants, shared with the write-side logic.
REQ-022 One sub-module, sync_2ff (parameterized WIDTH, rd_clk, rst_n, async reset to 0), SHALL implement REQ-003.

Verification
REQ-023 Reset check: after reset, check empty=1, out_valid=0, rd_count=0, rd_ptr_gray=0, mem_rd_en=0.
REQ-024 Single word: drive wr_ptr_gray 0->1 with memory word 0xA5 -> out_valid rises after edge 3 with out_data=0xA5, and empty=1 after the pop.
REQ-025 Backpressure: fill 16 words 0x00..0x0F with out_ready=0 ->
- occ stops at 2 and mem_rd_en stays 0 with rd_count=14;
- out_data holds 0x00;
- after releasing out_ready, 0x00..0x0F arrive in order at 1 word per cycle.
REQ-026 Full and wrap: write 16, read 16, write 16 more (wr_ptr 31->0 wrap) -> rd_count reaches 16 with empty=0, all 32 words arrive in order, and rd_ptr_gray ends at 0.
REQ-027 Random stall: 1000 words under random out_ready and random write bursts -> scoreboard matches, and rd_ptr_gray changes at most 1 bit per cycle.
REQ-028 Mid-stream reset: assert rst_n=0 with occ=2 and inflight=1 -> all outputs are at reset values immediately, and no stale word appears after release.
